// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its controller.
// DEPTH must be a power of two: the controller pointers wrap by natural overflow.
package instr_register_pkg;

    localparam int DEPTH = 8;

    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef logic signed [31:0]        operand_t;
    typedef logic [$clog2(DEPTH)-1:0]  index_t;
    typedef logic [$clog2(DEPTH):0]    count_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_FLUSH
    } ctrl_state_t;

    function automatic index_t idx_inc(index_t i);
        return i + index_t'(1);
    endfunction

endpackage

// File: rtl/instr_reg_ctrl_if.sv
// Producer/consumer bus of the instruction register controller.
// master: the environment (two producers, one consumer, flush source); slave: the controller.
interface instr_reg_ctrl_if;
    import instr_register_pkg::*;

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    instruction_t [1:0] req_instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    instruction_t       out_instr;
    count_t             count;

    modport master (
        output req_valid, req_instr, flush, out_ready,
        input  req_ready, out_valid, out_instr, count
    );

    modport slave (
        input  req_valid, req_instr, flush, out_ready,
        output req_ready, out_valid, out_instr, count
    );

endinterface

// File: rtl/instr_register.sv
// Instruction storage array: synchronous write port, combinational read port.
// reset_en is a synchronous active-low clear of every entry.
module instr_register
    import instr_register_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_reset_en,
    input  logic         i_load_en,
    input  index_t       i_write_index,
    input  opcode_t      i_opcode,
    input  operand_t     i_operand_a,
    input  operand_t     i_operand_b,
    input  index_t       i_read_index,
    output instruction_t o_instruction
);

    instruction_t r_mem [DEPTH];

    // clear on reset, otherwise store one entry per load_en cycle
    always_ff @(posedge i_clk) begin
        if (!i_reset_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_load_en) begin
            r_mem[i_write_index] <= '{opc: i_opcode, op_a: i_operand_a, op_b: i_operand_b};
        end
    end

    assign o_instruction = r_mem[i_read_index];

endmodule

// File: rtl/instr_rr_arb2.sv
// Two-way arbiter granting at most one requester per cycle.
// Default: round-robin, the requester not granted last wins a tie.
// INSTR_CTRL_FIXED_PRIO_EN defined: requester 0 always wins a tie.
module instr_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_reset_en,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // index of the requester granted most recently; 1 after reset so requester 0 wins first
    logic       r_last;
    logic [1:0] w_gnt;

    // pick the winner among the active requests
    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:
`ifdef INSTR_CTRL_FIXED_PRIO_EN
                         w_gnt = 2'b01;
`else
                         w_gnt = r_last ? 2'b01 : 2'b10;
`endif
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign o_gnt = w_gnt;

    // remember who won for the next tie
    always_ff @(posedge i_clk) begin
        if (!i_reset_en) begin
            r_last <= 1'b1;
        end else if (w_gnt[0]) begin
            r_last <= 1'b0;
        end else if (w_gnt[1]) begin
            r_last <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Controller in front of instr_register: arbitrates two producers onto the
// single write port, allocates write slots circularly and streams entries in
// write order to one consumer. Also sequences the register clear after reset
// and the flush of all stored entries.
// Build option INSTR_CTRL_FIXED_PRIO_EN: fixed priority to producer 0 on ties.
//
//   state   | meaning
//   S_INIT  | register held in reset for INIT_CYCLES cycles, no traffic
//   S_RUN   | accept writes, serve reads
//   S_FLUSH | one cycle: drop all stored entries (rd_ptr <= wr_ptr)
module instr_reg_ctrl
    import instr_register_pkg::*;
#(
    parameter int INIT_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_en,
    instr_reg_ctrl_if.slave  ctrl,
    output logic             o_reg_reset_en,
    output logic             o_load_en,
    output index_t           o_write_index,
    output opcode_t          o_opcode,
    output operand_t         o_operand_a,
    output operand_t         o_operand_b,
    output index_t           o_read_index,
    input  instruction_t     i_instruction
);

    localparam int INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);

    ctrl_state_t  r_state;
    ctrl_state_t  w_state_nxt;
    logic [INIT_W-1:0] r_init_cnt;

    index_t       r_wr_ptr;
    index_t       r_rd_ptr;
    count_t       r_count;
    logic         r_load_en;
    index_t       r_write_index;
    opcode_t      r_opcode;
    operand_t     r_operand_a;
    operand_t     r_operand_b;

    logic         w_run;
    logic         w_space;
    logic         w_arb_en;
    logic [1:0]   w_gnt;
    logic         w_out_valid;
    logic         w_rd;
    count_t       w_occ;
    instruction_t w_sel;

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) w_state_nxt = S_RUN;
            S_RUN:   if (ctrl.flush) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // state register and init timer
    always_ff @(posedge i_clk) begin
        if (!i_reset_en) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) begin
                r_init_cnt <= r_init_cnt + INIT_W'(1);
            end
        end
    end

    // Occupancy includes the write still in flight, so a slot freed by a read
    // this cycle only becomes available next cycle.
    assign w_run       = (r_state == S_RUN) && !ctrl.flush;
    assign w_occ       = r_count + count_t'(r_load_en);
    assign w_space     = w_occ < count_t'(DEPTH);
    assign w_arb_en    = w_run && w_space;
    assign w_out_valid = w_run && (r_count != '0);
    assign w_rd        = w_out_valid && ctrl.out_ready;
    assign w_sel       = w_gnt[1] ? ctrl.req_instr[1] : ctrl.req_instr[0];

    instr_rr_arb2 u_arb (
        .i_clk      (i_clk),
        .i_reset_en (i_reset_en),
        .i_en       (w_arb_en),
        .i_req      (ctrl.req_valid),
        .o_gnt      (w_gnt)
    );

    // write staging, pointers and committed occupancy
    always_ff @(posedge i_clk) begin
        if (!i_reset_en) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_load_en     <= 1'b0;
            r_write_index <= '0;
            r_opcode      <= ZERO;
            r_operand_a   <= '0;
            r_operand_b   <= '0;
        end else begin
            r_load_en <= |w_gnt;
            if (|w_gnt) begin
                r_write_index <= r_wr_ptr;
                r_opcode      <= w_sel.opc;
                r_operand_a   <= w_sel.op_a;
                r_operand_b   <= w_sel.op_b;
                r_wr_ptr      <= idx_inc(r_wr_ptr);
            end
            if (r_state == S_FLUSH) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= '0;
            end else begin
                if (w_rd) begin
                    r_rd_ptr <= idx_inc(r_rd_ptr);
                end
                r_count <= r_count + count_t'(r_load_en) - count_t'(w_rd);
            end
        end
    end

    assign ctrl.req_ready  = w_gnt;
    assign ctrl.out_valid  = w_out_valid;
    assign ctrl.out_instr  = i_instruction;
    assign ctrl.count      = r_count;

    assign o_reg_reset_en  = (r_state != S_INIT);
    assign o_load_en       = r_load_en;
    assign o_write_index   = r_write_index;
    assign o_opcode        = r_opcode;
    assign o_operand_a     = r_operand_a;
    assign o_operand_b     = r_operand_b;
    assign o_read_index    = r_rd_ptr;

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Directed bench for instr_reg_ctrl driving a real instr_register.
module tb_instr_reg_ctrl;
    import instr_register_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_en;
    logic         reg_reset_en;
    logic         load_en;
    index_t       write_index;
    index_t       read_index;
    opcode_t      opcode;
    operand_t     operand_a;
    operand_t     operand_b;
    instruction_t instruction;

    instr_reg_ctrl_if bus ();

    instr_reg_ctrl #(.INIT_CYCLES(4)) dut (
        .i_clk          (clk),
        .i_reset_en     (reset_en),
        .ctrl           (bus),
        .o_reg_reset_en (reg_reset_en),
        .o_load_en      (load_en),
        .o_write_index  (write_index),
        .o_opcode       (opcode),
        .o_operand_a    (operand_a),
        .o_operand_b    (operand_b),
        .o_read_index   (read_index),
        .i_instruction  (instruction)
    );

    instr_register u_reg (
        .i_clk         (clk),
        .i_reset_en    (reg_reset_en),
        .i_load_en     (load_en),
        .i_write_index (write_index),
        .i_opcode      (opcode),
        .i_operand_a   (operand_a),
        .i_operand_b   (operand_b),
        .i_read_index  (read_index),
        .o_instruction (instruction)
    );

    int           n_vec = 0;
    int           n_err = 0;
    instruction_t exp_q[$];
    index_t       exp_wr;
    index_t       exp_rd;
    int           rr_next;
    int           a0;
    int           a1;

    function automatic instruction_t mk(opcode_t o, int a, int b);
        instruction_t t;
        t.opc  = o;
        t.op_a = operand_t'(a);
        t.op_b = operand_t'(b);
        return t;
    endfunction

    task automatic drive_both();
        bus.req_valid    = 2'b11;
        bus.req_instr[0] = mk(ADD, a0, 1);
        bus.req_instr[1] = mk(SUB, a1, 2);
    endtask

    task automatic test_reset();
        int low_cnt;
        reset_en      = 1'b0;
        bus.req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (reg_reset_en !== 1'b0) begin n_err++; $display("FAIL rst_reg_reset_en got %0b want 0", reg_reset_en); end
        n_vec++; if (load_en !== 1'b0) begin n_err++; $display("FAIL rst_load_en got %0b want 0", load_en); end
        n_vec++; if (write_index !== 3'd0) begin n_err++; $display("FAIL rst_write_index got %0d want 0", write_index); end
        n_vec++; if (opcode !== ZERO || operand_a !== 0 || operand_b !== 0) begin n_err++; $display("FAIL rst_fields got %0h/%0h/%0h want 0/0/0", opcode, operand_a, operand_b); end
        n_vec++; if (read_index !== 3'd0) begin n_err++; $display("FAIL rst_read_index got %0d want 0", read_index); end
        n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", bus.count); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
        n_vec++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready got %0b want 00", bus.req_ready); end
        bus.req_valid = 2'b00;
        reset_en      = 1'b1;
        low_cnt       = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (reg_reset_en === 1'b1) break;
            low_cnt++;
            @(negedge clk);
        end
        n_vec++; if (low_cnt !== 4) begin n_err++; $display("FAIL init_low_cycles got %0d want 4", low_cnt); end
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.out_ready    = 1'b1;
        bus.req_valid    = 2'b01;
        bus.req_instr[0] = mk(ADD, 5, 7);
        bus.req_instr[1] = mk(SUB, 9, 9);
        #1;
        n_vec++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %0b want 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        n_vec++; if (load_en !== 1'b1 || write_index !== 3'd0) begin n_err++; $display("FAIL single_load got %0b@%0d want 1@0", load_en, write_index); end
        n_vec++; if (opcode !== ADD || operand_a !== 5 || operand_b !== 7) begin n_err++; $display("FAIL single_fields got %0h/%0d/%0d want ADD/5/7", opcode, operand_a, operand_b); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass got %0b want 0", bus.out_valid); end
        @(negedge clk);
        #1;
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid got %0b want 1", bus.out_valid); end
        n_vec++; if (bus.out_instr !== mk(ADD, 5, 7)) begin n_err++; $display("FAIL single_out_instr got %0h want %0h", bus.out_instr, mk(ADD, 5, 7)); end
        @(negedge clk);
        #1;
        n_vec++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained got cnt %0d v %0b want 0 0", bus.count, bus.out_valid); end
        n_vec++; if (read_index !== 3'd1) begin n_err++; $display("FAIL single_read_index got %0d want 1", read_index); end
        bus.out_ready = 1'b0;
        exp_wr  = 3'd1;
        exp_rd  = 3'd1;
        rr_next = 1;
    endtask

    task automatic test_round_robin();
        int         acc;
        logic       prev_ld;
        index_t     prev_idx;
        logic [1:0] exp_rdy;
        acc      = 0;
        prev_ld  = 1'b0;
        prev_idx = '0;
        a0       = 100;
        a1       = 200;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_both();
            #1;
            exp_rdy = (acc < DEPTH) ? ((rr_next == 1) ? 2'b10 : 2'b01) : 2'b00;
            n_vec++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant[%0d] got %0b want %0b", i, bus.req_ready, exp_rdy); end
            n_vec++; if (load_en !== prev_ld) begin n_err++; $display("FAIL rr_load_en[%0d] got %0b want %0b", i, load_en, prev_ld); end
            if (prev_ld) begin
                n_vec++; if (write_index !== prev_idx) begin n_err++; $display("FAIL rr_write_index[%0d] got %0d want %0d", i, write_index, prev_idx); end
            end
            prev_ld = (acc < DEPTH);
            if (acc < DEPTH) begin
                prev_idx = exp_wr;
                if (rr_next == 1) begin exp_q.push_back(mk(SUB, a1, 2)); a1++; rr_next = 0; end
                else              begin exp_q.push_back(mk(ADD, a0, 1)); a0++; rr_next = 1; end
                exp_wr++;
                acc++;
            end
            @(negedge clk);
        end
        drive_both();
        #1;
        n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL rr_full_count got %0d want 8", bus.count); end
        n_vec++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL rr_full_stall got %0b want 00", bus.req_ready); end
        n_vec++; if (read_index !== exp_rd) begin n_err++; $display("FAIL rr_read_index got %0d want %0d", read_index, exp_rd); end
    endtask

    task automatic test_full_read();
        logic [1:0] exp_rdy;
        index_t     idx;
        @(negedge clk);
        drive_both();
        bus.out_ready = 1'b1;
        #1;
        n_vec++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL full_rd_same_cycle got %0b want 00", bus.req_ready); end
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== exp_q[0]) begin n_err++; $display("FAIL full_rd_data got %0b/%0h want 1/%0h", bus.out_valid, bus.out_instr, exp_q[0]); end
        void'(exp_q.pop_front());
        exp_rd++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        exp_rdy = (rr_next == 1) ? 2'b10 : 2'b01;
        n_vec++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL full_next_accept got %0b want %0b", bus.req_ready, exp_rdy); end
        n_vec++; if (bus.count !== 4'd7 || read_index !== exp_rd) begin n_err++; $display("FAIL full_after_read got cnt %0d rd %0d want 7 %0d", bus.count, read_index, exp_rd); end
        if (rr_next == 1) begin exp_q.push_back(mk(SUB, a1, 2)); a1++; rr_next = 0; end
        else              begin exp_q.push_back(mk(ADD, a0, 1)); a0++; rr_next = 1; end
        idx = exp_wr;
        exp_wr++;
        @(negedge clk);
        drive_both();
        #1;
        n_vec++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL full_pending_stall got %0b want 00", bus.req_ready); end
        n_vec++; if (load_en !== 1'b1 || write_index !== idx) begin n_err++; $display("FAIL full_wrap_index got %0b@%0d want 1@%0d", load_en, write_index, idx); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL full_count_stays got %0d want 8", bus.count); end
    endtask

    task automatic test_drain();
        int got;
        got = 0;
        for (int k = 0; k < 20 && got < DEPTH; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid === 1'b1) begin
                n_vec++; if (bus.out_instr !== exp_q[0] || read_index !== exp_rd) begin n_err++; $display("FAIL drain[%0d] got %0h@%0d want %0h@%0d", got, bus.out_instr, read_index, exp_q[0], exp_rd); end
                void'(exp_q.pop_front());
                exp_rd++;
                got++;
            end
        end
        n_vec++; if (got !== DEPTH) begin n_err++; $display("FAIL drain_entries got %0d want %0d", got, DEPTH); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        n_vec++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got cnt %0d v %0b want 0 0", bus.count, bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid    = 2'b01;
            bus.req_instr[0] = mk(MULT, i, 3);
            #1;
            n_vec++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL flush_fill[%0d] got %0b want 01", i, bus.req_ready); end
            exp_wr++;
        end
        rr_next = 1;
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        n_vec++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL flush_no_accept got %0b want 00", bus.req_ready); end
        n_vec++; if (load_en !== 1'b1 || bus.count !== 4'd3) begin n_err++; $display("FAIL flush_pre got ld %0b cnt %0d want 1 3", load_en, bus.count); end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        n_vec++; if (bus.req_ready !== 2'b00 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_state got rdy %0b v %0b want 00 0", bus.req_ready, bus.out_valid); end
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        n_vec++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || load_en !== 1'b0) begin n_err++; $display("FAIL flush_cleared got cnt %0d v %0b ld %0b want 0 0 0", bus.count, bus.out_valid, load_en); end
        n_vec++; if (read_index !== exp_wr) begin n_err++; $display("FAIL flush_rd_eq_wr got %0d want %0d", read_index, exp_wr); end
        exp_rd = exp_wr;
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_second;
        a0 = 500;
        a1 = 600;
        @(negedge clk);
        drive_both();
        bus.out_ready = 1'b1;
        #1;
        n_vec++; if (bus.req_ready !== 2'b10) begin n_err++; $display("FAIL mid_pre_grant got %0b want 10", bus.req_ready); end
        @(negedge clk);
        #1;
        n_vec++; if (load_en !== 1'b1) begin n_err++; $display("FAIL mid_stream_active got %0b want 1", load_en); end
        reset_en = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (bus.count !== 4'd0 || read_index !== 3'd0 || write_index !== 3'd0 || load_en !== 1'b0) begin n_err++; $display("FAIL mid_reset_state got cnt %0d rd %0d wi %0d ld %0b want 0 0 0 0", bus.count, read_index, write_index, load_en); end
        n_vec++; if (reg_reset_en !== 1'b0 || bus.req_ready !== 2'b00) begin n_err++; $display("FAIL mid_reset_init got rre %0b rdy %0b want 0 00", reg_reset_en, bus.req_ready); end
        reset_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (reg_reset_en === 1'b1) break;
            @(negedge clk);
        end
        n_vec++; if (reg_reset_en !== 1'b1) begin n_err++; $display("FAIL mid_init_timeout got %0b want 1", reg_reset_en); end
        n_vec++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL mid_first_grant got %0b want 01", bus.req_ready); end
        @(negedge clk);
        #1;
`ifdef INSTR_CTRL_FIXED_PRIO_EN
        exp_second = 2'b01;
`else
        exp_second = 2'b10;
`endif
        n_vec++; if (bus.req_ready !== exp_second) begin n_err++; $display("FAIL mid_second_grant got %0b want %0b", bus.req_ready, exp_second); end
        n_vec++; if (load_en !== 1'b1 || write_index !== 3'd0 || opcode !== ADD) begin n_err++; $display("FAIL mid_restart_write got %0b@%0d op %0h want 1@0 ADD", load_en, write_index, opcode); end
        bus.req_valid = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset_en      = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_instr = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        exp_wr        = '0;
        exp_rd        = '0;
        rr_next       = 0;
        a0            = 0;
        a1            = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_read();
        test_drain();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
